// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA geometry and colour format, used by the timing
// generator and by the background/sprite renderers.
package vga_pkg;

    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 521;
    localparam int H_SYNC_PIX   = 96;
    localparam int V_SYNC_LINES = 2;

    localparam int H_VIS_START  = 144;
    localparam int H_VIS_END    = 783;
    localparam int V_VIS_START  = 31;
    localparam int V_VIS_END    = 510;

    localparam int RED_W        = 3;
    localparam int GREEN_W      = 3;
    localparam int BLUE_W       = 2;
    localparam int COLOR_W      = RED_W + GREEN_W + BLUE_W;
    localparam int CNT_W        = 10;

    typedef logic [CNT_W-1:0] count_t;

    // Pixel colour as delivered by the renderers: RRRGGGBB.
    typedef struct packed {
        logic [RED_W-1:0]   red;
        logic [GREEN_W-1:0] green;
        logic [BLUE_W-1:0]  blue;
    } rgb_t;

    function automatic logic is_visible(input count_t h, input count_t v);
        return (h >= count_t'(H_VIS_START)) && (h <= count_t'(H_VIS_END)) &&
               (v >= count_t'(V_VIS_START)) && (v <= count_t'(V_VIS_END));
    endfunction

endpackage

// File: rtl/pix_clk_div.sv
// Pixel-rate divider: a 0..PIX_DIV-1 count whose terminal value becomes a
// registered one-clk pix_tick strobe.
module pix_clk_div #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             at_last;

    assign at_last = (div_cnt == DIV_LAST);

    // The strobe is registered so it stays low in the reset cycle even with
    // PIX_DIV=1, and the first tick lands exactly PIX_DIV cycles after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= at_last;
            div_cnt  <= at_last ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator: pixel/line counters, registered syncs and
// DAC drive, plus frame_start and a once-per-N-frames animation tick.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV         = 4,
    parameter int FRAMES_PER_TICK = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] color_in,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       tick_1s
);

    localparam count_t     H_LAST     = count_t'(H_TOTAL - 1);
    localparam count_t     V_LAST     = count_t'(V_TOTAL - 1);
    localparam count_t     H_SYNC_END = count_t'(H_SYNC_PIX);
    localparam count_t     V_SYNC_END = count_t'(V_SYNC_LINES);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_TICK - 1);

    logic       line_end;
    logic       frame_end;
    logic [7:0] frame_cnt;
    rgb_t       pixel;

    pix_clk_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_clk_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    assign line_end  = (h_count == H_LAST);
    assign frame_end = line_end && (v_count == V_LAST);
    assign pixel     = rgb_t'(color_in);

    // Line and frame wrap in one step when both ends coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_tick) begin
            if (line_end) begin
                h_count <= '0;
                v_count <= frame_end ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Syncs and colour come from the same pre-increment counts, so they
    // trail h_count/v_count by exactly one pixel together.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pix_tick) begin
            hsync <= (h_count >= H_SYNC_END);
            vsync <= (v_count >= V_SYNC_END);
            if (is_visible(h_count, v_count)) begin
                red   <= pixel.red;
                green <= pixel.green;
                blue  <= pixel.blue;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
            tick_1s     <= 1'b0;
        end else begin
            frame_start <= pix_tick && frame_end;
            tick_1s     <= pix_tick && frame_end && (frame_cnt == FRAME_LAST);
            if (pix_tick && frame_end) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter PIX_DIV, default 4: clk cycles per pixel; legal range 1..16.
REQ-002 Parameter FRAMES_PER_TICK, default 60: frames per tick_1s pulse; legal range 1..255.
REQ-003 clk  in  1: single system clock; all logic on its rising edge.
REQ-004 rst  in  1: synchronous, active-high reset.
REQ-005 color_in  in  8: pixel colour from the background/sprite renderers, RRRGGGBB, for the pixel at the current h_count/v_count.
REQ-006 h_count  out  10: horizontal pixel counter, 0..799.
REQ-007 v_count  out  10: vertical line counter, 0..520.
REQ-008 hsync  out  1: horizontal sync, active low.
REQ-009 vsync  out  1: vertical sync, active low.
REQ-010 red  out  3, green  out  3, blue  out  2: registered DAC drive.
REQ-011 pix_tick  out  1: one-clk pulse on each pixel advance.
REQ-012 frame_start  out  1: one-clk pulse when both counters wrap to 0.
REQ-013 tick_1s  out  1: one-clk pulse every FRAMES_PER_TICK frames; drives animation counters.

Function
REQ-014 The divider SHALL count 0..PIX_DIV-1 and assert pix_tick when it equals PIX_DIV-1; with PIX_DIV=1, pix_tick SHALL be high every cycle.
REQ-015 On pix_tick, h_count SHALL increment; at 799 it SHALL wrap to 0.
REQ-016 v_count SHALL increment only when h_count wraps; at 520 it SHALL wrap to 0.
REQ-017 Visible region SHALL be h_count 144..783 and v_count 31..510, inclusive (640x480).
REQ-018 hsync SHALL be low for h_count 0..95 and high otherwise.
REQ-019 vsync SHALL be low for v_count 0..1 and high otherwise.
REQ-020 On pix_tick, {red,green,blue} SHALL register color_in if the current counts are visible, and 0 otherwise.
REQ-021 hsync and vsync SHALL be registered on the same pix_tick from the same counts, so sync and RGB share one pixel of latency.
REQ-022 Between pix_ticks, all of h_count, v_count, hsync, vsync and RGB SHALL hold.
REQ-023 frame_start SHALL be asserted in the cycle the counters wrap from (799,520) to (0,0).
REQ-024 A frame counter SHALL count frame wraps 0..FRAMES_PER_TICK-1.
REQ-025 tick_1s SHALL pulse in the same cycle as the frame_start that completes FRAMES_PER_TICK frames, after which the frame counter SHALL return to 0.
REQ-026 The end of a line and the end of a frame in the same pix_tick SHALL be handled as a single event: both counters wrap, with no skipped or duplicated line.

Reset
REQ-027 When rst is high at a clock edge, the divider, h_count, v_count and the frame counter SHALL be 0.
REQ-028 In the same condition, RGB SHALL be 0, hsync and vsync SHALL be 1 (inactive), and pix_tick, frame_start and tick_1s SHALL be 0.
REQ-029 Reset asserted mid-line or mid-frame SHALL abort the frame.
REQ-030 After rst deasserts, the first pix_tick SHALL occur PIX_DIV cycles later.

Structure
REQ-031 H/V totals, sync widths, visible bounds (144, 783, 31, 510) and the colour width SHALL be constants in a shared vga_pkg package, used by the renderers too.
REQ-032 The pixel divider SHALL be one sub-module, pix_clk_div.
REQ-033 All other logic SHALL be flat in vga_timing_gen.

Verification
REQ-034 PIX_DIV=4, reset released: pix_tick SHALL pulse every 4 clk; h_count SHALL reach 799 after 3200 clk, then wrap to 0 with v_count=1.
REQ-035 Full frame: hsync SHALL be low for 96 pixels per line; vsync SHALL be low for lines 0..1; frame_start SHALL pulse once per 800*521 pixels.
REQ-036 color_in=8'hE3 held constant: RGB SHALL equal 3'b111/3'b000/2'b11 only for registered counts h 144..783, v 31..510, and 0 at h=143, 784 and v=30, 511.
REQ-037 FRAMES_PER_TICK=2: tick_1s SHALL coincide with every second frame_start only.
REQ-038 rst pulsed at h_count=400, v_count=200: the next cycle SHALL show counts 0, hsync=vsync=1, RGB=0; counting SHALL restart cleanly.
REQ-039 PIX_DIV=1: counts SHALL advance every clk, and the (799,520)->(0,0) wrap SHALL occur exactly once per 416800 clk.
